// File: rtl/puf_pkg.sv
// Shared state encoding, sizing helper and limits for the ring-oscillator PUF engine.
package puf_pkg;

    localparam int unsigned PUF_MIN_SETTLE = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEL  = 3'd1,
        ST_SNAP = 3'd2,
        ST_RUN  = 3'd3,
        ST_STOP = 3'd4,
        ST_CMP  = 3'd5,
        ST_DONE = 3'd6
    } puf_state_t;

    // Select width for one bank of n_ro/2 oscillators (at least 1 bit).
    function automatic int unsigned sel_w(input int unsigned n_ro);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < (n_ro / 2)) w++;
        return w;
    endfunction

endpackage

// File: rtl/puf_edge_ctr.sv
// Free-running edge counter clocked directly by a selected ring-oscillator line.
module puf_edge_ctr
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             ro_clk,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
    end

    // Never cleared: only differences between two snapshots are meaningful.
    always_ff @(posedge ro_clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/puf_word.sv
// Ring-oscillator PUF engine: RESP_W sequential pairwise frequency races per challenge.
module puf_word
    import puf_pkg::*;
#(
    parameter int unsigned N_RO   = 32,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned RESP_W = 8,
    parameter int unsigned WINDOW = 1024,
    parameter int unsigned SETTLE = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [2*sel_w(N_RO)-1:0]    chall,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [RESP_W-1:0]           resp,
    output logic                        tie,
    output logic [N_RO-1:0]             ro_en,
    input  logic [N_RO-1:0]             ro_in
);

    localparam int unsigned SEL_W    = sel_w(N_RO);
    localparam int unsigned SETTLE_C = (SETTLE < PUF_MIN_SETTLE) ? PUF_MIN_SETTLE : SETTLE;
    localparam int unsigned TMR_MAX  = (WINDOW > SETTLE_C) ? WINDOW : SETTLE_C;
    localparam int unsigned TMR_W    = $clog2(TMR_MAX);
    localparam int unsigned IDX_W    = (RESP_W > 1) ? $clog2(RESP_W) : 1;

    puf_state_t          state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [2*SEL_W-1:0]  chall_q, chall_d;
    logic [SEL_W-1:0]    sel_a_q, sel_a_d;
    logic [SEL_W-1:0]    sel_b_q, sel_b_d;
    logic [CNT_W-1:0]    snap_a_q, snap_a_d;
    logic [CNT_W-1:0]    snap_b_q, snap_b_d;
    logic [RESP_W-1:0]   resp_q, resp_d;
    logic                tie_q, tie_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [N_RO-1:0]     ro_en_q, ro_en_d;

    logic                ro_a, ro_b;
    logic [CNT_W-1:0]    cnt_a, cnt_b;
    logic [CNT_W-1:0]    diff_a, diff_b;

    // Bank muxes: selects come straight from flops and only move while all ROs are stopped.
    assign ro_a = ro_in[{1'b0, sel_a_q}];
    assign ro_b = ro_in[{1'b1, sel_b_q}];

    puf_edge_ctr #(.CNT_W(CNT_W)) u_ctr_a (.ro_clk(ro_a), .cnt(cnt_a));
    puf_edge_ctr #(.CNT_W(CNT_W)) u_ctr_b (.ro_clk(ro_b), .cnt(cnt_b));

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        idx_d    = idx_q;
        chall_d  = chall_q;
        snap_a_d = snap_a_q;
        snap_b_d = snap_b_q;
        resp_d   = resp_q;
        tie_d    = tie_q;
        diff_a   = cnt_a - snap_a_q;
        diff_b   = cnt_b - snap_b_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    chall_d = chall;
                    resp_d  = '0;
                    tie_d   = 1'b0;
                    idx_d   = '0;
                    tmr_d   = '0;
                    state_d = ST_SEL;
                end
            end
            ST_SEL: begin
                if (tmr_q == TMR_W'(SETTLE_C - 1)) begin
                    tmr_d   = '0;
                    state_d = ST_SNAP;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_SNAP: begin
                snap_a_d = cnt_a;
                snap_b_d = cnt_b;
                tmr_d    = '0;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                if (tmr_q == TMR_W'(WINDOW - 1)) begin
                    tmr_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_STOP: begin
                if (tmr_q == TMR_W'(SETTLE_C - 1)) begin
                    tmr_d   = '0;
                    state_d = ST_CMP;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_CMP: begin
                for (int unsigned j = 0; j < RESP_W; j++) begin
                    if (idx_q == IDX_W'(j)) resp_d[j] = (diff_a > diff_b);
                end
                if (diff_a == diff_b) tie_d = 1'b1;
                if (idx_q == IDX_W'(RESP_W - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_SEL;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they switch with it.
        sel_a_d = chall_d[SEL_W-1:0] + SEL_W'(idx_d);
        sel_b_d = chall_d[2*SEL_W-1:SEL_W] + SEL_W'(idx_d);
        busy_d  = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d  = (state_d == ST_DONE);
        ro_en_d = '0;
        if (state_d == ST_RUN) begin
            ro_en_d[{1'b0, sel_a_d}] = 1'b1;
            ro_en_d[{1'b1, sel_b_d}] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            idx_q    <= '0;
            chall_q  <= '0;
            sel_a_q  <= '0;
            sel_b_q  <= '0;
            snap_a_q <= '0;
            snap_b_q <= '0;
            resp_q   <= '0;
            tie_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ro_en_q  <= '0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            idx_q    <= idx_d;
            chall_q  <= chall_d;
            sel_a_q  <= sel_a_d;
            sel_b_q  <= sel_b_d;
            snap_a_q <= snap_a_d;
            snap_b_q <= snap_b_d;
            resp_q   <= resp_d;
            tie_q    <= tie_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ro_en_q  <= ro_en_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign resp  = resp_q;
    assign tie   = tie_q;
    assign ro_en = ro_en_q;

endmodule
